// File: rtl/snd_seq_ctrl.sv
// Sound command sequencer: ROM walker driving tone-generator register writes.
// Optional build macro SND_SEQ_LOOP_EN: END restarts the program instead of finishing.
module snd_seq_ctrl #(
  parameter int                ADDR_W     = 13,
  parameter logic [ADDR_W-1:0] START_ADDR = 13'h0000,
  parameter logic [11:0]       TEMPO_RST  = 12'd1
) (
  input  logic              clk,
  input  logic              asyncrst,
  input  logic              start,
  input  logic              stop,
  input  logic              tick,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic              wr_en,
  output logic [1:0]        wr_ch,
  output logic [1:0]        wr_sel,
  output logic [7:0]        wr_data,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [3:0] {
    IDLE,
    FETCH,
    RDWAIT,
    DECODE,
    OPFETCH,
    OPWAIT,
    KEYON,
    HOLD,
    KEYOFF,
    STOPPED
  } state_t;

  localparam logic [1:0] SEL_VOL  = 2'd0;
  localparam logic [1:0] SEL_INST = 2'd1;
  localparam logic [1:0] SEL_ON   = 2'd2;
  localparam logic [1:0] SEL_OFF  = 2'd3;

  state_t            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [11:0]       tempo_q;
  logic [11:0]       pcnt_q;
  logic [11:0]       cnt_q;
  logic              note_q;
  logic [1:0]        ch_q;
  logic [7:0]        arg_q;
  logic              wr_en_q;
  logic [1:0]        wr_ch_q;
  logic [1:0]        wr_sel_q;
  logic [7:0]        wr_data_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;

  logic [3:0]        op;
  logic [1:0]        ch;
  logic [7:0]        arg;
  logic [11:0]       n;
  logic              step_d;
  logic              pwrap_d;
  logic [ADDR_W-1:0] pc_d;
  logic              op_wait;
  logic              op_tempo;
  logic              op_vol;
  logic              op_inst;
  logic              op_note;
  logic              op_end;

  assign op  = rom_data[15:12];
  assign ch  = rom_data[9:8];
  assign arg = rom_data[7:0];
  assign n   = rom_data[11:0];

  assign op_wait  = (op == 4'h0);
  assign op_tempo = (op == 4'h1);
  assign op_vol   = (op == 4'h2);
  assign op_inst  = (op == 4'h3);
  assign op_note  = (op == 4'h4);
  assign op_end   = (op == 4'hF);

  // Adding one in ADDR_W bits wraps the last ROM word back to zero.
  assign pc_d    = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
  assign pwrap_d = (pcnt_q == tempo_q - 12'd1);
  assign step_d  = busy_q && tick && pwrap_d;

  assign rom_addr = pc_q;
  assign wr_en    = wr_en_q;
  assign wr_ch    = wr_ch_q;
  assign wr_sel   = wr_sel_q;
  assign wr_data  = wr_data_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;

  always_ff @(posedge clk or posedge asyncrst) begin
    if (asyncrst) begin
      state_q   <= IDLE;
      pc_q      <= START_ADDR;
      tempo_q   <= TEMPO_RST;
      pcnt_q    <= 12'd0;
      cnt_q     <= 12'd0;
      note_q    <= 1'b0;
      ch_q      <= 2'd0;
      arg_q     <= 8'd0;
      wr_en_q   <= 1'b0;
      wr_ch_q   <= 2'd0;
      wr_sel_q  <= 2'd0;
      wr_data_q <= 8'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      if (busy_q && tick) begin
        pcnt_q <= pwrap_d ? 12'd0 : pcnt_q + 12'd1;
      end
      if (stop) begin
        busy_q <= 1'b0;
        // A sounding note is silenced once on abort.
        if (state_q == KEYON || (state_q == HOLD && note_q)) begin
          wr_en_q   <= 1'b1;
          wr_ch_q   <= ch_q;
          wr_sel_q  <= SEL_OFF;
          wr_data_q <= 8'd0;
          state_q   <= STOPPED;
        end else begin
          state_q <= IDLE;
        end
      end else if (start && !busy_q) begin
        busy_q  <= 1'b1;
        done_q  <= 1'b0;
        err_q   <= 1'b0;
        tempo_q <= TEMPO_RST;
        pcnt_q  <= 12'd0;
        pc_q    <= START_ADDR;
        note_q  <= 1'b0;
        state_q <= FETCH;
      end else begin
        case (state_q)
          IDLE: state_q <= IDLE;
          STOPPED: state_q <= IDLE;
          FETCH: state_q <= RDWAIT;
          RDWAIT: state_q <= DECODE;
          DECODE: begin
            unique case (1'b1)
              op_wait: begin
                pc_q   <= pc_d;
                note_q <= 1'b0;
                cnt_q  <= n;
                state_q <= (n == 12'd0) ? FETCH : HOLD;
              end
              op_tempo: begin
                pc_q    <= pc_d;
                tempo_q <= (n == 12'd0) ? 12'd1 : n;
                pcnt_q  <= 12'd0;
                state_q <= FETCH;
              end
              op_vol, op_inst: begin
                pc_q      <= pc_d;
                wr_en_q   <= 1'b1;
                wr_ch_q   <= ch;
                wr_sel_q  <= op_vol ? SEL_VOL : SEL_INST;
                wr_data_q <= arg;
                state_q   <= FETCH;
              end
              op_note: begin
                pc_q    <= pc_d;
                ch_q    <= ch;
                arg_q   <= arg;
                state_q <= OPFETCH;
              end
              op_end: begin
`ifdef SND_SEQ_LOOP_EN
                pc_q    <= START_ADDR;
                state_q <= FETCH;
`else
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                state_q <= IDLE;
`endif
              end
              default: begin
                busy_q  <= 1'b0;
                err_q   <= 1'b1;
                state_q <= IDLE;
              end
            endcase
          end
          OPFETCH: state_q <= OPWAIT;
          OPWAIT: begin
            wr_en_q   <= 1'b1;
            wr_ch_q   <= ch_q;
            wr_sel_q  <= SEL_ON;
            wr_data_q <= arg_q;
            state_q   <= KEYON;
          end
          KEYON: begin
            // Duration word is still on rom_data here.
            pc_q   <= pc_d;
            note_q <= 1'b1;
            cnt_q  <= n;
            if (n == 12'd0) begin
              wr_en_q   <= 1'b1;
              wr_ch_q   <= ch_q;
              wr_sel_q  <= SEL_OFF;
              wr_data_q <= 8'd0;
              state_q   <= KEYOFF;
            end else begin
              state_q <= HOLD;
            end
          end
          HOLD: begin
            if (step_d) begin
              if (cnt_q == 12'd1) begin
                if (note_q) begin
                  wr_en_q   <= 1'b1;
                  wr_ch_q   <= ch_q;
                  wr_sel_q  <= SEL_OFF;
                  wr_data_q <= 8'd0;
                  state_q   <= KEYOFF;
                end else begin
                  state_q <= FETCH;
                end
              end else begin
                cnt_q <= cnt_q - 12'd1;
              end
            end
          end
          KEYOFF: begin
            note_q  <= 1'b0;
            state_q <= FETCH;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_snd_seq_ctrl.sv
// Directed bench for snd_seq_ctrl with a registered-read ROM model.
module tb_snd_seq_ctrl;

  typedef struct {
    int         c;
    logic [1:0] ch;
    logic [1:0] sel;
    logic [7:0] d;
  } wr_t;

  logic        clk = 1'b0;
  logic        asyncrst;
  logic        start, start1, stop, tick;
  logic [12:0] rom_addr, rom_addr1;
  logic [15:0] rom_data, rom_data1;
  logic        wr_en, wr_en1;
  logic [1:0]  wr_ch, wr_ch1, wr_sel, wr_sel1;
  logic [7:0]  wr_data, wr_data1;
  logic        busy, busy1, done, done1, err, err1;

  logic [15:0] mem [0:8191];
  int          cyc = 0;
  int          tests = 0;
  int          fails = 0;
  wr_t         log_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rom_data <= mem[rom_addr];
  always @(posedge clk) rom_data1 <= mem[rom_addr1];
  always @(negedge clk) if (wr_en) log_q.push_back('{cyc, wr_ch, wr_sel, wr_data});

  snd_seq_ctrl dut (
    .clk(clk), .asyncrst(asyncrst), .start(start), .stop(stop),
    .tick(tick), .rom_addr(rom_addr), .rom_data(rom_data),
    .wr_en(wr_en), .wr_ch(wr_ch), .wr_sel(wr_sel), .wr_data(wr_data),
    .busy(busy), .done(done), .err(err)
  );

  snd_seq_ctrl #(.START_ADDR(13'h1FFF)) dut1 (
    .clk(clk), .asyncrst(asyncrst), .start(start1), .stop(stop),
    .tick(tick), .rom_addr(rom_addr1), .rom_data(rom_data1),
    .wr_en(wr_en1), .wr_ch(wr_ch1), .wr_sel(wr_sel1), .wr_data(wr_data1),
    .busy(busy1), .done(done1), .err(err1)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [15:0] w0, input logic [15:0] w1,
                      input logic [15:0] w2);
    for (int i = 0; i < 8; i++) mem[i] = 16'hF000;
    mem[0] = w0;
    mem[1] = w1;
    mem[2] = w2;
  endtask

  task automatic go(output int t0);
    log_q.delete();
    start = 1'b1;
    cycles(1);
    start = 1'b0;
    t0 = cyc;
  endtask

  task automatic wait_idle(input int max, output int k);
    k = 0;
    while (busy && k < max) begin
      cycles(1);
      k++;
    end
    chk("idle_timeout", busy, 1'b0);
  endtask

  function automatic wr_t ent(input int i);
    wr_t e;
    e = '{-1, 2'd0, 2'd0, 8'd0};
    if (i < log_q.size()) e = log_q[i];
    return e;
  endfunction

  initial begin
    int  t0, k;
    wr_t e0, e1;
    for (int i = 0; i < 8192; i++) mem[i] = 16'hF000;
    asyncrst = 1'b1;
    start = 1'b0;
    start1 = 1'b0;
    stop = 1'b0;
    tick = 1'b0;
    cycles(3);
    chk("rst_addr", rom_addr, 13'h0000);
    chk("rst_addr1", rom_addr1, 13'h1FFF);
    chk("rst_out", {wr_en, wr_ch, wr_sel, wr_data}, 13'h0);
    chk("rst_flags", {busy, done, err}, 3'b000);
    asyncrst = 1'b0;
    cycles(2);

    // single VOL write then END
    load(16'h2001, 16'hF000, 16'hF000);
    go(t0);
    chk("t1_busy", busy, 1'b1);
    wait_idle(50, k);
    chk("t1_len", k, 6);
    chk("t1_flags", {busy, done, err}, 3'b010);
    e0 = ent(0);
    chk("t1_nwr", log_q.size(), 1);
    chk("t1_lat", e0.c - t0, 3);
    chk("t1_wr", {e0.ch, e0.sel, e0.d}, {2'd0, 2'd0, 8'h01});

    // TEMPO 3 then WAIT 2 with tick every cycle
    load(16'h1003, 16'h0002, 16'hF000);
    tick = 1'b1;
    go(t0);
    chk("t2_done_clr", done, 1'b0);
    wait_idle(100, k);
    chk("t2_len", k, 15);
    chk("t2_done", done, 1'b1);
    chk("t2_nwr", log_q.size(), 0);

    // NOTE ch1 0x20 held 4 steps at reset tempo
    load(16'h4120, 16'h0004, 16'hF000);
    go(t0);
    wait_idle(100, k);
    chk("t3_len", k, 14);
    chk("t3_nwr", log_q.size(), 2);
    e0 = ent(0);
    e1 = ent(1);
    chk("t3_on_t", e0.c - t0, 5);
    chk("t3_on", {e0.ch, e0.sel, e0.d}, {2'd1, 2'd2, 8'h20});
    chk("t3_off_t", e1.c - e0.c, 5);
    chk("t3_off", {e1.ch, e1.sel, e1.d}, {2'd1, 2'd3, 8'h00});

    // NOTE with zero duration
    load(16'h4020, 16'h0000, 16'hF000);
    go(t0);
    wait_idle(100, k);
    chk("t4_len", k, 10);
    chk("t4_nwr", log_q.size(), 2);
    e0 = ent(0);
    e1 = ent(1);
    chk("t4_gap", e1.c - e0.c, 1);
    chk("t4_sels", {e0.sel, e1.sel, e1.d}, {2'd2, 2'd3, 8'h00});

    // stop during a long HOLD, then start+stop together
    load(16'h4030, 16'h0100, 16'hF000);
    tick = 1'b0;
    go(t0);
    cycles(8);
    stop = 1'b1;
    cycles(1);
    stop = 1'b0;
    chk("t5_off", {wr_en, wr_ch, wr_sel, wr_data}, {1'b1, 2'd0, 2'd3, 8'h00});
    chk("t5_flags", {busy, done}, 2'b00);
    cycles(1);
    chk("t5_wr_once", wr_en, 1'b0);
    chk("t5_nwr", log_q.size(), 2);
    start = 1'b1;
    stop = 1'b1;
    cycles(1);
    start = 1'b0;
    stop = 1'b0;
    chk("t5_ss_busy", busy, 1'b0);
    cycles(3);
    chk("t5_ss_idle", {busy, wr_en}, 2'b00);
    chk("t5_ss_nwr", log_q.size(), 2);

    // illegal opcode
    load(16'h5000, 16'hF000, 16'hF000);
    go(t0);
    wait_idle(50, k);
    chk("t6_len", k, 3);
    chk("t6_flags", {busy, done, err}, 3'b001);
    chk("t6_addr", rom_addr, 13'h0000);

    // async reset in the middle of a held note
    load(16'h4030, 16'h0100, 16'hF000);
    go(t0);
    chk("t7_err_clr", err, 1'b0);
    cycles(8);
    chk("t7_addr_run", rom_addr, 13'h0002);
    #2 asyncrst = 1'b1;
    #1;
    chk("t7_rst", {busy, wr_en, rom_addr}, {2'b00, 13'h0000});
    asyncrst = 1'b0;
    cycles(3);
    chk("t7_nwr", log_q.size(), 1);
    chk("t7_idle", busy, 1'b0);

    // START_ADDR at the top of the ROM wraps to zero
    mem[13'h1FFF] = 16'h2001;
    mem[0] = 16'hF000;
    start1 = 1'b1;
    cycles(1);
    start1 = 1'b0;
    cycles(2);
    chk("t8_pre", wr_en1, 1'b0);
    cycles(1);
    chk("t8_wr", {wr_en1, wr_ch1, wr_sel1, wr_data1}, {1'b1, 2'd0, 2'd0, 8'h01});
    chk("t8_wrap", rom_addr1, 13'h0000);
    cycles(3);
    chk("t8_flags", {busy1, done1, err1}, 3'b010);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
